ram_loader: RTL
===============

Name: ram_loader

Overview:
- Write-side master for the Hack RAM/ROM memory interface.
- Receives a byte stream from a host link (UART RX or similar) and assembles big-endian 16-bit words.
- Writes each word to consecutive addresses from 0 and holds the CPU in reset for the whole load.
- Sits between the host byte receiver and the memory write port (data / address / write-enable).

Parameters:
- DEPTH, 2**14, memory depth in words; address width is $clog2(DEPTH).
- WIDTH, 16, memory word width; must be 16 (two bytes per word).

Ports:
- i_CLK  input  1  system clock; all logic on posedge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Start  input  1  one-cycle pulse that begins a load; sampled only in IDLE or DONE.
- i_Word_Count  input  $clog2(DEPTH)+1  number of words to load; sampled on accepted i_Start.
- i_Byte  input  8  incoming byte.
- i_Byte_Valid  input  1  i_Byte is valid.
- o_Byte_Ready  output  1  loader accepts a byte this cycle.
- o_Address  output  $clog2(DEPTH)  memory address.
- o_Data  output  WIDTH  memory write data.
- o_Write_EN  output  1  memory write strobe.
- o_Busy  output  1  load in progress.
- o_Done  output  1  load complete; sticky until next accepted i_Start or reset.
- o_CPU_Reset  output  1  high in every state except DONE.

Behaviour:
- Reset values: state IDLE, o_Address=0, o_Data=0, o_Write_EN=0, o_Byte_Ready=0, o_Busy=0, o_Done=0, o_CPU_Reset=1, internal counter=0.
- Reset mid-load aborts immediately, even during WRITE; no further writes occur.
- Byte transfer happens on a cycle where i_Byte_Valid && o_Byte_Ready.
- o_Byte_Ready is high only in states HI and LO.
- States and transitions:
  - IDLE: on i_Start → clear address and counter, latch the count (clamped to DEPTH if larger), then go to HI. If the latched count is 0, go to DONE instead.
  - HI: on transfer, o_Data[15:8] <= i_Byte, then go to LO.
  - LO: on transfer, o_Data[7:0] <= i_Byte, then go to WRITE.
  - WRITE: o_Write_EN=1 for exactly one cycle, with o_Address and o_Data stable. Next cycle, go to VERIFY if LOADER_VERIFY_EN is defined, else go to NEXT.
  - NEXT: counter+1. If the counter reaches the latched count → DONE; else o_Address+1 → HI.
  - DONE: o_Done=1, o_CPU_Reset=0. An i_Start restarts the load (same as in IDLE).
- i_Start in any other state is ignored.
- Per-word latency: fastest is 4 cycles (HI, LO, WRITE, NEXT) with continuously valid bytes; 5 cycles with the verify feature.
- o_Busy=1 in HI, LO, WRITE, VERIFY and NEXT.
- o_Address never exceeds DEPTH-1. The count clamp guarantees no wrap during a load.
- o_Write_EN is never asserted outside WRITE.

Optional Feature:
- Macro: LOADER_VERIFY_EN.
- Defined:
  - Extra input i_Read_Data (WIDTH bits) connected to the memory's asynchronous read output.
  - Extra output o_Verify_Error (1 bit).
  - VERIFY state: address held, write disabled; compare i_Read_Data with o_Data.
  - A mismatch sets o_Verify_Error, which stays sticky until reset or the next accepted i_Start.
  - VERIFY → NEXT; the error does not stop the load.
- Undefined: no VERIFY state, no extra ports; WRITE → NEXT directly.

Decomposition:
- Shared package/header (ifndef-guarded): state encodings (IDLE, HI, LO, WRITE, VERIFY, NEXT, DONE) and the BYTES_PER_WORD=2 constant.
- One natural sub-module, byte_word_assembler: a byte-to-word shifter with its own hi/lo phase.
- The FSM may alternatively keep the assembler inline.

Test Plan:
- Reset, then Start with count=2 and bytes 0x12,0x34,0xAB,0xCD continuously valid:
  - Writes 0x1234@0 and 0xABCD@1, one strobe each.
  - o_Done=1 and o_CPU_Reset=0 after the final NEXT.
  - Exactly 2 strobes total.
- Byte stalls: i_Byte_Valid toggles every other cycle, count=1, bytes 0xBE,0xEF → a single write of 0xBEEF@0 with no extra strobes.
- count=0 → DONE the cycle after Start, with no writes and o_Byte_Ready never high.
- count=DEPTH+5 → clamped; the last write is at DEPTH-1, then DONE with no address wrap.
- Reset asserted in LO after the high byte 0x55 → all outputs at reset values next cycle, no write issued. A new Start then reloads from address 0.
- LOADER_VERIFY_EN, with a memory model that corrupts address 3 → o_Verify_Error rises in the VERIFY cycle of word 3; the load still completes with o_Done=1.

Source files
------------

// File: rtl/ram_loader_pkg.sv
// Shared definitions for the Hack RAM/ROM loader: FSM state encoding and word geometry.
`ifndef RAM_LOADER_PKG_SV
`define RAM_LOADER_PKG_SV
`default_nettype none

package ram_loader_pkg;

  localparam int BYTES_PER_WORD = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HI     = 3'd1,
    ST_LO     = 3'd2,
    ST_WRITE  = 3'd3,
    ST_VERIFY = 3'd4,
    ST_NEXT   = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

endpackage

`default_nettype wire
`endif

// File: rtl/ram_loader_if.sv
// Byte-link and memory-write-port bundle for ram_loader.
// Optional read-back signals exist only when LOADER_VERIFY_EN is defined.
`default_nettype none

interface ram_loader_if #(
  parameter int DEPTH = 2**14,
  parameter int WIDTH = 16
) ();
  localparam int AW = $clog2(DEPTH);

  logic             i_Start;
  logic [AW:0]      i_Word_Count;
  logic [7:0]       i_Byte;
  logic             i_Byte_Valid;
  logic             o_Byte_Ready;
  logic [AW-1:0]    o_Address;
  logic [WIDTH-1:0] o_Data;
  logic             o_Write_EN;
  logic             o_Busy;
  logic             o_Done;
  logic             o_CPU_Reset;
`ifdef LOADER_VERIFY_EN
  logic [WIDTH-1:0] i_Read_Data;
  logic             o_Verify_Error;
`endif

  modport master (
`ifdef LOADER_VERIFY_EN
    input  i_Read_Data,
    output o_Verify_Error,
`endif
    input  i_Start, i_Word_Count, i_Byte, i_Byte_Valid,
    output o_Byte_Ready, o_Address, o_Data, o_Write_EN,
    output o_Busy, o_Done, o_CPU_Reset
  );

  modport slave (
`ifdef LOADER_VERIFY_EN
    output i_Read_Data,
    input  o_Verify_Error,
`endif
    output i_Start, i_Word_Count, i_Byte, i_Byte_Valid,
    input  o_Byte_Ready, o_Address, o_Data, o_Write_EN,
    input  o_Busy, o_Done, o_CPU_Reset
  );

endinterface

`default_nettype wire

// File: rtl/ram_loader_byte_word_assembler.sv
// Big-endian byte-to-word shifter: first accepted byte fills the upper half, second the lower.
`default_nettype none

module byte_word_assembler
  import ram_loader_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             take,
  input  logic [7:0]       byte_in,
  output logic [WIDTH-1:0] word
);
  localparam int BYTE_BITS = WIDTH / BYTES_PER_WORD;

  logic phase_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      word     <= '0;
      phase_lo <= 1'b0;
    end else if (clear) begin
      phase_lo <= 1'b0;
    end else if (take) begin
      if (phase_lo) begin
        word[BYTE_BITS-1:0] <= byte_in;
      end else begin
        word[WIDTH-1 -: BYTE_BITS] <= byte_in;
      end
      phase_lo <= ~phase_lo;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_loader.sv
// Host-byte-stream to memory loader: writes big-endian words from address 0, holds the CPU in reset.
// Optional macro LOADER_VERIFY_EN adds a read-back compare state and a sticky error flag.
`default_nettype none

module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int DEPTH = 2**14,
  parameter int WIDTH = 16
) (
  input  logic         i_CLK,
  input  logic         i_Reset,
  ram_loader_if.master bus
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] MAX_COUNT = (AW+1)'(DEPTH);

  state_t           state, state_nx;
  logic [AW-1:0]    address;
  logic [AW:0]      count, target, count_inc, count_req;
  logic [WIDTH-1:0] data_word;
  logic             start_ok, take, byte_ready, write_en, busy, done, cpu_reset;

  assign count_inc = count + 1'b1;
  // Clamping the request keeps the address from wrapping past DEPTH-1.
  assign count_req = (bus.i_Word_Count > MAX_COUNT) ? MAX_COUNT : bus.i_Word_Count;
  assign take      = bus.i_Byte_Valid && byte_ready;

  always_comb begin
    state_nx   = state;
    start_ok   = 1'b0;
    byte_ready = 1'b0;
    write_en   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    cpu_reset  = 1'b1;
    case (state)
      ST_IDLE, ST_DONE: begin
        busy = 1'b0;
        if (state == ST_DONE) begin
          done      = 1'b1;
          cpu_reset = 1'b0;
        end
        if (bus.i_Start) begin
          start_ok = 1'b1;
          state_nx = (count_req == '0) ? ST_DONE : ST_HI;
        end
      end
      ST_HI: begin
        byte_ready = 1'b1;
        if (bus.i_Byte_Valid) state_nx = ST_LO;
      end
      ST_LO: begin
        byte_ready = 1'b1;
        if (bus.i_Byte_Valid) state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        write_en = 1'b1;
`ifdef LOADER_VERIFY_EN
        state_nx = ST_VERIFY;
`else
        state_nx = ST_NEXT;
`endif
      end
`ifdef LOADER_VERIFY_EN
      ST_VERIFY: state_nx = ST_NEXT;
`endif
      ST_NEXT: state_nx = (count_inc == target) ? ST_DONE : ST_HI;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_Reset) begin
      state   <= ST_IDLE;
      address <= '0;
      count   <= '0;
      target  <= '0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        address <= '0;
        count   <= '0;
        target  <= count_req;
      end else if (state == ST_NEXT) begin
        count <= count_inc;
        if (count_inc != target) address <= address + 1'b1;
      end
    end
  end

  byte_word_assembler #(.WIDTH(WIDTH)) u_assembler (
    .clk     (i_CLK),
    .rst     (i_Reset),
    .clear   (start_ok),
    .take    (take),
    .byte_in (bus.i_Byte),
    .word    (data_word)
  );

`ifdef LOADER_VERIFY_EN
  logic verify_err, mismatch;

  assign mismatch = (state == ST_VERIFY) && (bus.i_Read_Data != data_word);

  always_ff @(posedge i_CLK) begin
    if (i_Reset || start_ok) begin
      verify_err <= 1'b0;
    end else if (mismatch) begin
      verify_err <= 1'b1;
    end
  end

  // The flag shows in the compare cycle itself, then holds via the sticky register.
  assign bus.o_Verify_Error = verify_err | mismatch;
`endif

  assign bus.o_Byte_Ready = byte_ready;
  assign bus.o_Address    = address;
  assign bus.o_Data       = data_word;
  assign bus.o_Write_EN   = write_en;
  assign bus.o_Busy       = busy;
  assign bus.o_Done       = done;
  assign bus.o_CPU_Reset  = cpu_reset;

endmodule

`default_nettype wire
